ps2_mouse_cmd_tx: RTL and testbench
===================================

Name: ps2_mouse_cmd_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the mouse, e.g. 0xF4 enable-reporting or 0xFF reset, and checks the device ACK.
- Sits beside the PS/2 receive controller that feeds mouse position and clicks into the chimp game.
- Performs the request-to-send sequence, then shifts out 8 data bits plus odd parity and stop, clocked by the device.
- Drives the shared PS/2 lines as open-drain outputs: output-enable 1 pulls the line low, 0 releases it.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles that PS/2 clock is held low before the request (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles allowed between device clock falling edges, or waiting for the first one (20 ms at 50 MHz).

Ports:
- clk  in  1: system clock.
- iReset  in  1: reset, asynchronous, active-low.
- iSend  in  1: one-cycle request to transmit iCommand.
- iCommand  in  8: command byte, sampled on the cycle iSend is accepted.
- iPs2ClkIn  in  1: raw PS/2 clock line level.
- iPs2DatIn  in  1: raw PS/2 data line level.
- oPs2ClkOe  out  1: 1 = pull PS/2 clock low.
- oPs2DatOe  out  1: 1 = pull PS/2 data low.
- oBusy  out  1: transmission in progress.
- oDone  out  1: one-cycle pulse, command ACKed by device.
- oError  out  1: one-cycle pulse, NACK or timeout.

Behaviour:
- Reset (iReset=0, async): state IDLE; oPs2ClkOe=0, oPs2DatOe=0, oBusy=0, oDone=0, oError=0; counters cleared.
  - Reset mid-transfer releases both lines immediately and produces no oDone/oError pulse.
- Input synchronisation:
  - iPs2ClkIn and iPs2DatIn each pass through a 2-flop synchroniser.
  - A falling edge is the synced clock going 1 to 0 between consecutive cycles.
  - Edge detection adds 3 cycles of latency; this is acceptable against the 30-50 us PS/2 bit period.
- Accept: in IDLE, iSend=1 latches iCommand and parity = ~^iCommand (odd parity). Next state is INHIBIT, and oBusy=1 from the next cycle.
  - iSend while oBusy=1 is ignored: no queueing, latched byte unchanged.
- INHIBIT: oPs2ClkOe=1, oPs2DatOe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: one cycle with oPs2ClkOe=1, oPs2DatOe=1 (start bit 0), then go to SHIFT.
- SHIFT:
  - oPs2ClkOe=0 (clock released); data keeps driving start bit 0.
  - Bit counter n counts device falling edges 1..10 and updates data on each:
    - edges 1-8: data line = iCommand[n-1] (LSB first), i.e. oPs2DatOe = ~bit;
    - edge 9: parity bit;
    - edge 10: oPs2DatOe=0 (stop bit 1, line released).
  - After edge 10, go to ACK.
- ACK:
  - On the 11th falling edge, sample synced data.
  - Sampled 0: go to WAIT_IDLE.
  - Sampled 1: NACK; pulse oError, go to IDLE.
- WAIT_IDLE: wait until synced clock=1 and synced data=1, then pulse oDone, go to IDLE.
- Timeout:
  - The timeout counter runs in SHIFT, ACK and WAIT_IDLE, and resets on each device falling edge.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse oError, go to IDLE.
- oBusy falls in the same cycle oDone or oError pulses. oDone and oError are never high together.
- Both OE outputs are registered, with no combinational path from the inputs.
- Outside INHIBIT and RTS, oPs2ClkOe is always 0. The block never drives either line high.

Test Plan:
- Sim params INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. Bus-functional mouse model: clock period 40 cycles, samples data on rising edges, ACKs on the 11th clock.
- iSend with iCommand=0xF4:
  - oPs2ClkOe high for exactly 20 cycles, then RTS.
  - Model receives start 0, data bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Model ACKs 0, then oDone pulses once and oBusy drops.
- iCommand=0xFF: parity bit 1 received. iCommand=0x00: parity bit 1 received. Both end in oDone.
- Model holds data high on the 11th clock: oError pulses once, no oDone, both OEs 0.
- Model stops clocking after 4 edges: oError exactly 200 cycles after the 4th falling edge, lines released, back in IDLE (a new iSend is accepted).
- iSend=1 with 0x55 during a 0xF4 transfer: transmitted bits are still 0xF4, and a single oDone results.
- iReset=0 pulse during SHIFT: oPs2ClkOe=oPs2DatOe=oBusy=0 asynchronously, no oDone/oError. A following iSend completes normally.

Source files
------------

// File: rtl/ps2_mouse_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_mouse_cmd_tx
// Description : Host-to-device PS/2 command transmitter. Sends one command
//               byte to the mouse (for example 0xF4 enable-reporting or
//               0xFF reset) and checks the device acknowledge bit.
//               The shared PS/2 lines are open-drain: an output-enable of 1
//               pulls the line low and 0 releases it.
// Ports       : clk        - system clock
//               iReset     - asynchronous active-low reset
//               iSend      - one-cycle request to transmit iCommand
//               iCommand   - command byte, latched when iSend is accepted
//               iPs2ClkIn  - raw PS/2 clock line level
//               iPs2DatIn  - raw PS/2 data line level
//               oPs2ClkOe  - 1 pulls PS/2 clock low
//               oPs2DatOe  - 1 pulls PS/2 data low
//               oBusy      - transmission in progress
//               oDone      - one-cycle pulse, command acknowledged
//               oError     - one-cycle pulse, NACK or timeout
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_cmd_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iSend,
  input  logic [7:0] iCommand,
  input  logic       iPs2ClkIn,
  input  logic       iPs2DatIn,
  output logic       oPs2ClkOe,
  output logic       oPs2DatOe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  // One counter serves both the inhibit interval and the timeout, since
  // they are never active at the same time.
  localparam int c_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic [c_CNT_W-1:0] r_cnt, w_cnt;
  logic [3:0]         r_bitCnt, w_bitCnt;
  logic [7:0]         r_cmd, w_cmd;
  logic               r_parity, w_parity;
  logic               r_clkOe, w_clkOe;
  logic               r_datOe, w_datOe;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_error, w_error;

  // Synchronisers reset to 1 (idle bus level) so reset release never looks
  // like a falling edge.
  logic [1:0]         r_clkSync;
  logic [1:0]         r_datSync;
  logic               r_clkPrev;
  logic               w_fall;
  logic               w_timeout;

  assign w_fall    = r_clkPrev & ~r_clkSync[1];
  assign w_timeout = (r_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
      r_clkPrev <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bitCnt  <= '0;
      r_cmd     <= '0;
      r_parity  <= 1'b0;
      r_clkOe   <= 1'b0;
      r_datOe   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_clkSync <= {r_clkSync[0], iPs2ClkIn};
      r_datSync <= {r_datSync[0], iPs2DatIn};
      r_clkPrev <= r_clkSync[1];
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bitCnt  <= w_bitCnt;
      r_cmd     <= w_cmd;
      r_parity  <= w_parity;
      r_clkOe   <= w_clkOe;
      r_datOe   <= w_datOe;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_error   <= w_error;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bitCnt = r_bitCnt;
    w_cmd    = r_cmd;
    w_parity = r_parity;
    w_clkOe  = 1'b0;
    w_datOe  = r_datOe;
    w_done   = 1'b0;
    w_error  = 1'b0;

    case (r_state)
      IDLE: begin
        w_datOe = 1'b0;
        if (iSend) begin
          w_cmd    = iCommand;
          w_parity = ~^iCommand;
          w_cnt    = '0;
          w_clkOe  = 1'b1;
          w_state  = INHIBIT;
        end
      end

      INHIBIT: begin
        w_clkOe = 1'b1;
        if (r_cnt == c_INH_LAST) begin
          w_cnt   = '0;
          w_datOe = 1'b1;          // start bit goes out together with RTS
          w_state = RTS;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      RTS: begin
        // Clock is released from the next cycle; data keeps the start bit.
        w_cnt    = '0;
        w_bitCnt = '0;
        w_state  = SHIFT;
      end

      SHIFT: begin
        if (w_fall) begin
          w_cnt    = '0;
          w_bitCnt = r_bitCnt + 4'd1;
          if (r_bitCnt < 4'd8) begin
            w_datOe = ~r_cmd[r_bitCnt[2:0]];
          end else if (r_bitCnt == 4'd8) begin
            w_datOe = ~r_parity;
          end else begin
            w_datOe = 1'b0;        // stop bit: line released
            w_state = ACK;
          end
        end else if (w_timeout) begin
          w_datOe = 1'b0;
          w_error = 1'b1;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ACK: begin
        if (w_fall) begin
          w_cnt = '0;
          if (r_datSync[1]) begin
            w_error = 1'b1;
            w_state = IDLE;
          end else begin
            w_state = WAIT_IDLE;
          end
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (r_clkSync[1] && r_datSync[1]) begin
          w_done  = 1'b1;
          w_state = IDLE;
        end else if (w_fall) begin
          w_cnt = '0;
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_datOe = 1'b0;
        w_state = IDLE;
      end
    endcase

    // Busy follows the next state so it drops on the same edge that raises
    // the done/error pulse.
    w_busy = (w_state != IDLE);
  end

  assign oPs2ClkOe = r_clkOe;
  assign oPs2DatOe = r_datOe;
  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oError    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_mouse_cmd_tx
// Description : Directed self-checking bench for ps2_mouse_cmd_tx with a
//               bus-functional PS/2 mouse (40-cycle clock period, samples
//               data on rising edges, acknowledges on the 11th clock).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_cmd_tx;

  localparam int c_INH = 20;
  localparam int c_TO  = 200;

  logic       clk;
  logic       iReset;
  logic       iSend;
  logic [7:0] iCommand;
  logic       oPs2ClkOe;
  logic       oPs2DatOe;
  logic       oBusy;
  logic       oDone;
  logic       oError;

  logic mouseClk;
  logic mouseDat;
  logic ps2Clk;
  logic ps2Dat;

  // Wired-AND open-drain bus
  assign ps2Clk = mouseClk & ~oPs2ClkOe;
  assign ps2Dat = mouseDat & ~oPs2DatOe;

  ps2_mouse_cmd_tx #(
    .INHIBIT_CYCLES(c_INH),
    .TIMEOUT_CYCLES(c_TO)
  ) dut (
    .clk      (clk),
    .iReset   (iReset),
    .iSend    (iSend),
    .iCommand (iCommand),
    .iPs2ClkIn(ps2Clk),
    .iPs2DatIn(ps2Dat),
    .oPs2ClkOe(oPs2ClkOe),
    .oPs2DatOe(oPs2DatOe),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oError   (oError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int doneCnt     = 0;
  int errCnt      = 0;
  int errCyc      = 0;
  int lastFallCyc = 0;
  logic bothHigh    = 1'b0;
  logic busyOverlap = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (oDone) doneCnt++;
    if (oError) begin
      errCnt++;
      errCyc = cyc;
    end
    if (oDone && oError) bothHigh = 1'b1;
    if ((oDone || oError) && oBusy) busyOverlap = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendCmd(input logic [7:0] c);
    iSend    = 1'b1;
    iCommand = c;
    @(negedge clk);
    iSend    = 1'b0;
  endtask

  // Mouse side of one frame: waits for the request, samples the start bit,
  // then generates nEdges clock pulses. bits[i] is sampled on rising edge i.
  task automatic mouseFrame(input int nEdges, input logic ackBit, output logic [10:0] bits);
    int t;
    bits = '1;
    t = 0;
    while (!(oBusy && !oPs2ClkOe && oPs2DatOe) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    bits[0] = ps2Dat;
    for (int i = 1; i <= nEdges; i++) begin
      mouseClk    = 1'b0;
      lastFallCyc = cyc;
      repeat (20) @(negedge clk);
      mouseClk = 1'b1;
      if (i <= 10) bits[i] = ps2Dat;
      repeat (20) @(negedge clk);
      if (i == 10) mouseDat = ackBit;
    end
    mouseDat = 1'b1;
  endtask

  task automatic waitCount(input int which, input int target);
    int t;
    t = 0;
    while (((which == 0) ? doneCnt : errCnt) < target && t < 400) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    logic [10:0] frame;
    int n;
    int d0;
    int e0;

    iReset   = 1'b0;
    iSend    = 1'b0;
    iCommand = 8'h00;
    mouseClk = 1'b1;
    mouseDat = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_clkOe", {31'd0, oPs2ClkOe}, 32'd0);
    check("rst_datOe", {31'd0, oPs2DatOe}, 32'd0);
    check("rst_busy",  {31'd0, oBusy},     32'd0);
    check("rst_done",  {31'd0, oDone},     32'd0);
    check("rst_error", {31'd0, oError},    32'd0);
    iReset = 1'b1;
    repeat (3) @(negedge clk);

    // ---- 0xF4: inhibit length, RTS, frame bits, ACK ----
    d0 = doneCnt;
    sendCmd(8'hF4);
    check("f4_busy", {31'd0, oBusy}, 32'd1);
    n = 0;
    while (oPs2ClkOe && !oPs2DatOe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("f4_inhibit_len", n, c_INH);
    check("f4_rts", {30'd0, oPs2ClkOe, oPs2DatOe}, 32'd3);
    @(negedge clk);
    check("f4_shift_entry", {30'd0, oPs2ClkOe, oPs2DatOe}, 32'd1);
    mouseFrame(11, 1'b0, frame);
    check("f4_frame", {21'd0, frame}, 32'h5E8);
    waitCount(0, d0 + 1);
    repeat (5) @(negedge clk);
    check("f4_done", doneCnt - d0, 32'd1);
    check("f4_busy_low", {31'd0, oBusy}, 32'd0);

    // ---- 0xFF: parity 1 ----
    d0 = doneCnt;
    sendCmd(8'hFF);
    mouseFrame(11, 1'b0, frame);
    check("ff_frame", {21'd0, frame}, 32'h7FE);
    waitCount(0, d0 + 1);
    check("ff_done", doneCnt - d0, 32'd1);

    // ---- 0x00: parity 1 ----
    d0 = doneCnt;
    sendCmd(8'h00);
    mouseFrame(11, 1'b0, frame);
    check("00_frame", {21'd0, frame}, 32'h600);
    waitCount(0, d0 + 1);
    check("00_done", doneCnt - d0, 32'd1);

    // ---- NACK ----
    d0 = doneCnt;
    e0 = errCnt;
    sendCmd(8'hF4);
    mouseFrame(11, 1'b1, frame);
    waitCount(1, e0 + 1);
    repeat (10) @(negedge clk);
    check("nack_error", errCnt - e0, 32'd1);
    check("nack_no_done", doneCnt - d0, 32'd0);
    check("nack_oe", {30'd0, oPs2ClkOe, oPs2DatOe}, 32'd0);
    check("nack_busy", {31'd0, oBusy}, 32'd0);

    // ---- Timeout after 4 edges: 200 cycles + 3 cycles detect latency ----
    d0 = doneCnt;
    e0 = errCnt;
    sendCmd(8'hF4);
    mouseFrame(4, 1'b0, frame);
    waitCount(1, e0 + 1);
    check("to_error", errCnt - e0, 32'd1);
    check("to_latency", errCyc - lastFallCyc, c_TO + 3);
    check("to_no_done", doneCnt - d0, 32'd0);
    check("to_oe", {30'd0, oPs2ClkOe, oPs2DatOe}, 32'd0);
    check("to_busy", {31'd0, oBusy}, 32'd0);

    // ---- New send accepted; 0x55 during transfer is ignored ----
    d0 = doneCnt;
    sendCmd(8'hF4);
    check("resend_busy", {31'd0, oBusy}, 32'd1);
    repeat (5) @(negedge clk);
    sendCmd(8'h55);
    mouseFrame(11, 1'b0, frame);
    check("ignore_frame", {21'd0, frame}, 32'h5E8);
    waitCount(0, d0 + 1);
    repeat (20) @(negedge clk);
    check("ignore_done", doneCnt - d0, 32'd1);

    // ---- Reset during SHIFT ----
    d0 = doneCnt;
    e0 = errCnt;
    sendCmd(8'h00);
    mouseFrame(3, 1'b0, frame);
    check("mid_datOe_before", {31'd0, oPs2DatOe}, 32'd1);
    iReset = 1'b0;
    #1;
    check("mid_rst_oe", {30'd0, oPs2ClkOe, oPs2DatOe}, 32'd0);
    check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
    @(negedge clk);
    iReset = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_pulse", (doneCnt - d0) + (errCnt - e0), 32'd0);
    d0 = doneCnt;
    sendCmd(8'hFF);
    mouseFrame(11, 1'b0, frame);
    check("after_rst_frame", {21'd0, frame}, 32'h7FE);
    waitCount(0, d0 + 1);
    check("after_rst_done", doneCnt - d0, 32'd1);

    check("never_both", {31'd0, bothHigh}, 32'd0);
    check("busy_drops_with_pulse", {31'd0, busyOverlap}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
